// File: rtl/vend_ctrl_param_if.sv
// Vending controller port bundle: coin/selection/cancel from the front panel,
// beverage/change valid-ready toward the dispenser.
interface vend_ctrl_param_if #(
  parameter int COIN_W = 16,
  parameter int SEL_W  = 2
);
  logic              coin_valid;
  logic [COIN_W-1:0] coin_in;
  logic              button_valid;
  logic [SEL_W-1:0]  button_in;
  logic              cancel;
  logic              out_ready;
  logic              beverage_valid;
  logic [SEL_W-1:0]  beverage_out;
  logic              change_valid;
  logic [COIN_W-1:0] change_out;
  logic [COIN_W-1:0] credit;
  logic              coin_reject;

  modport master (
    output coin_valid, coin_in, button_valid, button_in, cancel, out_ready,
    input  beverage_valid, beverage_out, change_valid, change_out, credit, coin_reject
  );

  modport slave (
    input  coin_valid, coin_in, button_valid, button_in, cancel, out_ready,
    output beverage_valid, beverage_out, change_valid, change_out, credit, coin_reject
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, priced selection, dispense, change return.
// Latency 1 cycle (all outputs registered); beverage/change held until out_ready.
module vend_ctrl_param #(
  parameter int N_BEV      = 4,
  parameter int COIN_W     = 16,
  parameter int PRICE_BASE = 50,
  parameter int PRICE_STEP = 25,
  parameter int MAX_CREDIT = 200
) (
  input logic               clk,
  input logic               rst,
  vend_ctrl_param_if.slave  bus
);
  localparam int SEL_W = (N_BEV > 1) ? $clog2(N_BEV) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t            state_q, state_d;
  logic [COIN_W-1:0] credit_q, credit_d;
  logic [COIN_W-1:0] change_out_q, change_out_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  bev_out_q, bev_out_d;
  logic              bev_vld_q, bev_vld_d;
  logic              chg_vld_q, chg_vld_d;
  logic              reject_q, reject_d;

  logic [63:0]       price;
  logic              sel_ok;
  logic [COIN_W:0]   coin_sum;
  logic              coin_fits;
  logic              coin_take;

  // A price that does not fit in COIN_W bits can never be selected.
  always_comb begin
    price     = 64'(PRICE_BASE) + 64'(bus.button_in) * 64'(PRICE_STEP);
    sel_ok    = (64'(bus.button_in) < 64'(N_BEV)) &&
                (price < (64'd1 << COIN_W)) &&
                (price <= 64'(credit_q));
    coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin_in};
    coin_fits = (bus.coin_in != '0) && (coin_sum <= (COIN_W+1)'(MAX_CREDIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      sel_q        <= '0;
      bev_vld_q    <= 1'b0;
      bev_out_q    <= '0;
      chg_vld_q    <= 1'b0;
      change_out_q <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      sel_q        <= sel_d;
      bev_vld_q    <= bev_vld_d;
      bev_out_q    <= bev_out_d;
      chg_vld_q    <= chg_vld_d;
      change_out_q <= change_out_d;
      reject_q     <= reject_d;
    end
  end

  // Priority while collecting: cancel, then button, then coin.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    sel_d     = sel_q;
    coin_take = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel && (state_q == COLLECT)) begin
          state_d = CHANGE;
        end else if (bus.button_valid && sel_ok) begin
          state_d  = DISPENSE;
          sel_d    = bus.button_in;
          credit_d = credit_q - price[COIN_W-1:0];
        end else if (bus.coin_valid && coin_fits) begin
          state_d   = COLLECT;
          credit_d  = coin_sum[COIN_W-1:0];
          coin_take = 1'b1;
        end
      end
      DISPENSE: begin
        if (bus.out_ready) state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (bus.out_ready) begin
          state_d  = IDLE;
          credit_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reject_d     = bus.coin_valid &&
                   ((state_q == DISPENSE) || (state_q == CHANGE) ||
                    ((bus.coin_in != '0) && !coin_take));
    bev_vld_d    = (state_d == DISPENSE);
    bev_out_d    = bev_vld_d ? sel_d : '0;
    chg_vld_d    = (state_d == CHANGE);
    change_out_d = chg_vld_d ? credit_d : '0;
  end

  assign bus.beverage_valid = bev_vld_q;
  assign bus.beverage_out   = bev_out_q;
  assign bus.change_valid   = chg_vld_q;
  assign bus.change_out     = change_out_q;
  assign bus.credit         = credit_q;
  assign bus.coin_reject    = reject_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Two controller instances (default pricing; 5 selections in 8-bit coins) driven in
// lockstep and checked every cycle against a purchase-level reference model.
module tb_vend_ctrl_param;
  logic clk = 1'b0;
  logic rst;
  logic cv, bv, cn, rdy;
  logic [15:0] coin;
  logic [2:0]  btn;

  int n_checks = 0;
  int n_fail   = 0;

  vend_ctrl_param_if #(.COIN_W(16), .SEL_W(2)) b0 ();
  vend_ctrl_param_if #(.COIN_W(8),  .SEL_W(3)) b1 ();

  vend_ctrl_param #(.N_BEV(4), .COIN_W(16), .PRICE_BASE(50), .PRICE_STEP(25), .MAX_CREDIT(200))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  vend_ctrl_param #(.N_BEV(5), .COIN_W(8), .PRICE_BASE(50), .PRICE_STEP(60), .MAX_CREDIT(250))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  assign b0.coin_valid   = cv;
  assign b0.coin_in      = coin;
  assign b0.button_valid = bv;
  assign b0.button_in    = btn[1:0];
  assign b0.cancel       = cn;
  assign b0.out_ready    = rdy;
  assign b1.coin_valid   = cv;
  assign b1.coin_in      = coin[7:0];
  assign b1.button_valid = bv;
  assign b1.button_in    = btn;
  assign b1.cancel       = cn;
  assign b1.out_ready    = rdy;

  always #5 clk = ~clk;

  // Reference model: credit held, beverage awaiting pickup (-1 none), refund awaiting pickup.
  int p_n[2]    = '{4, 5};
  int p_w[2]    = '{16, 8};
  int p_step[2] = '{25, 60};
  int p_max[2]  = '{200, 250};
  int m_credit[2];
  int m_vend[2];
  bit m_refund[2];
  bit m_rej[2];
  int coins[7]  = '{0, 5, 10, 25, 50, 100, 150};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_credit[k] = 0;
      m_vend[k]   = -1;
      m_refund[k] = 1'b0;
      m_rej[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int  c     = m_credit[k];
    int  b     = (k == 0) ? int'(btn[1:0]) : int'(btn);
    int  cval  = (k == 0) ? int'(coin) : int'(coin[7:0]);
    int  price = 50 + b * p_step[k];
    bit  used  = 1'b0;
    m_rej[k] = 1'b0;
    if (m_vend[k] >= 0) begin
      m_rej[k] = cv;
      if (rdy) begin
        m_vend[k]   = -1;
        m_refund[k] = (m_credit[k] > 0);
      end
    end else if (m_refund[k]) begin
      m_rej[k] = cv;
      if (rdy) begin
        m_refund[k] = 1'b0;
        m_credit[k] = 0;
      end
    end else begin
      if (cn && c > 0) begin
        m_refund[k] = 1'b1;
      end else if (bv && b < p_n[k] && price < (1 << p_w[k]) && price <= c) begin
        m_vend[k]   = b;
        m_credit[k] = c - price;
      end else if (cv && cval != 0 && c + cval <= p_max[k]) begin
        m_credit[k] = c + cval;
        used = 1'b1;
      end
      m_rej[k] = cv && cval != 0 && !used;
    end
  endtask

  task automatic compare_all();
    check("d0_bev_vld", b0.beverage_valid, m_vend[0] >= 0);
    check("d0_bev_out", b0.beverage_out, (m_vend[0] >= 0) ? m_vend[0] : 0);
    check("d0_chg_vld", b0.change_valid, m_refund[0]);
    check("d0_chg_out", b0.change_out, m_refund[0] ? m_credit[0] : 0);
    check("d0_credit",  b0.credit, m_credit[0]);
    check("d0_reject",  b0.coin_reject, m_rej[0]);
    check("d0_excl",    b0.beverage_valid & b0.change_valid, 0);
    check("d1_bev_vld", b1.beverage_valid, m_vend[1] >= 0);
    check("d1_bev_out", b1.beverage_out, (m_vend[1] >= 0) ? m_vend[1] : 0);
    check("d1_chg_vld", b1.change_valid, m_refund[1]);
    check("d1_chg_out", b1.change_out, m_refund[1] ? m_credit[1] : 0);
    check("d1_credit",  b1.credit, m_credit[1]);
    check("d1_reject",  b1.coin_reject, m_rej[1]);
    check("d1_excl",    b1.beverage_valid & b1.change_valid, 0);
  endtask

  task automatic cyc(input logic c_v, input int c, input logic b_v, input int b,
                     input logic c_n, input logic r);
    cv   = c_v;
    coin = 16'(c);
    bv   = b_v;
    btn  = 3'(b);
    cn   = c_n;
    rdy  = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic flush();
    cyc(0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    cv = 1'b0; coin = '0; bv = 1'b0; btn = '0; cn = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #2 rst = 1'b0;

    // Purchase with change
    cyc(1, 100, 0, 0, 0, 0);
    cyc(1, 50, 0, 0, 0, 0);
    check("s1_credit", b0.credit, 150);
    cyc(0, 0, 1, 2, 0, 0);
    check("s1_bev_vld", b0.beverage_valid, 1);
    check("s1_bev_out", b0.beverage_out, 2);
    cyc(0, 0, 0, 0, 0, 1);
    check("s1_chg_vld", b0.change_valid, 1);
    check("s1_chg_out", b0.change_out, 50);
    cyc(0, 0, 0, 0, 0, 1);
    check("s1_credit_end", b0.credit, 0);
    check("s1_chg_drop", b0.change_valid, 0);
    flush();

    // Exact payment: straight back to idle
    cyc(1, 50, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("s2_bev_out", b0.beverage_out, 0);
    check("s2_bev_vld", b0.beverage_valid, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("s2_no_chg", b0.change_valid, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("s2_no_chg2", b0.change_valid, 0);
    flush();

    // Too expensive, then cancel
    cyc(1, 50, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    check("s3_credit", b0.credit, 50);
    check("s3_no_bev", b0.beverage_valid, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("s3_chg_out", b0.change_out, 50);
    cyc(0, 0, 0, 0, 0, 1);
    check("s3_idle", b0.credit, 0);
    flush();

    // Credit ceiling, invalid index and unrepresentable price
    cyc(1, 100, 0, 0, 0, 0);
    cyc(1, 50, 0, 0, 0, 0);
    cyc(1, 100, 0, 0, 0, 0);
    check("s4_reject", b0.coin_reject, 1);
    check("s4_credit", b0.credit, 150);
    cyc(0, 0, 0, 0, 0, 0);
    check("s4_reject_pulse", b0.coin_reject, 0);
    cyc(0, 0, 1, 7, 0, 0);
    check("s4_d1_idx7", b1.beverage_valid, 0);
    check("s4_d1_credit", b1.credit, 250);
    cyc(0, 0, 1, 4, 0, 0);
    check("s4_d1_unrep", b1.beverage_valid, 0);
    flush();

    // Cancel + button + coin together, then stalled change
    cyc(1, 100, 0, 0, 0, 0);
    cyc(1, 50, 1, 0, 1, 0);
    check("s5_chg_vld", b0.change_valid, 1);
    check("s5_chg_out", b0.change_out, 100);
    check("s5_reject", b0.coin_reject, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("s5_hold_vld", b0.change_valid, 1);
      check("s5_hold_out", b0.change_out, 100);
    end
    cyc(0, 0, 0, 0, 0, 1);
    check("s5_done", b0.change_valid, 0);
    flush();

    // Asynchronous reset mid-dispense, then a normal purchase
    cyc(1, 50, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("s6_bev_vld", b0.beverage_valid, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("s6_rst_bev", b0.beverage_valid, 0);
    check("s6_rst_credit", b0.credit, 0);
    compare_all();
    #2 rst = 1'b0;
    cyc(1, 100, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    check("s6_bev_out", b0.beverage_out, 1);
    check("s6_credit", b0.credit, 25);
    cyc(0, 0, 0, 0, 0, 1);
    check("s6_chg_out", b0.change_out, 25);
    cyc(0, 0, 0, 0, 0, 1);
    check("s6_idle", b0.credit, 0);
    flush();

    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 9) < 4, coins[$urandom_range(0, 6)],
          $urandom_range(0, 9) < 2, int'($urandom_range(0, 7)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
